eh2_dec_trigger_csr: RTL

- Per-thread debug-trigger CSR file: tselect, tdata1 (mcontrol), tdata2 for 4 triggers per thread.
- Drives the trigger packets consumed by the decode and LSU trigger-match logic.
- Records trigger hits reported back by the pipeline.
- Sits in dec, next to the TLU; CSR accesses arrive from the TLU CSR path, already thread-tagged.

---
 rtl/eh2_pkg.sv | 32 +++
 rtl/eh2_dec_trigger_reg.sv | 103 ++++++++++
 rtl/eh2_dec_trigger_csr.sv | 103 ++++++++++
 3 files changed

// File: rtl/eh2_pkg.sv
// Shared debug-trigger types and constants for the EH2 decode trigger CSR file.
package eh2_pkg;

  typedef struct packed {
    logic        select;
    logic        match;
    logic        store;
    logic        load;
    logic        execute;
    logic        m;
    logic [31:0] tdata2;
  } eh2_trigger_pkt_t;

  localparam logic [11:0] TSELECT = 12'h7A0;
  localparam logic [11:0] TDATA1  = 12'h7A1;
  localparam logic [11:0] TDATA2  = 12'h7A2;

  localparam int unsigned TD1_DMODE   = 27;
  localparam int unsigned TD1_HIT     = 20;
  localparam int unsigned TD1_SELECT  = 19;
  localparam int unsigned TD1_ACTION  = 12;
  localparam int unsigned TD1_CHAIN   = 11;
  localparam int unsigned TD1_MATCH   = 7;
  localparam int unsigned TD1_M       = 6;
  localparam int unsigned TD1_EXECUTE = 2;
  localparam int unsigned TD1_STORE   = 1;
  localparam int unsigned TD1_LOAD    = 0;

  localparam logic [3:0] MCONTROL_TYPE    = 4'h2;
  localparam logic [5:0] MCONTROL_MAXMASK = 6'h1F;

endpackage

// File: rtl/eh2_dec_trigger_reg.sv
// One trigger's mcontrol/tdata2 state with dmode write guard and sticky hit.
// Chain storage exists only when EH2_TRIGGER_CHAIN_EN is defined and CHAIN_CAP is set.
module eh2_dec_trigger_reg
  import eh2_pkg::*;
#(
  parameter bit CHAIN_CAP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_tdata1,
  input  logic             i_wr_tdata2,
  input  logic [31:0]      i_wr_data,
  input  logic             i_dbg_mode,
  input  logic             i_hit_set,
  output logic [31:0]      o_tdata1,
  output logic             o_chain,
  output eh2_trigger_pkt_t o_pkt
);

  logic        r_dmode, r_hit, r_select, r_action, r_match, r_m;
  logic        r_execute, r_store, r_load;
  logic [31:0] r_tdata2;
  logic        w_wr_ok;
  logic        w_wr1;
  logic        w_chain;
  logic        w_unused_cfg;

  // A debug-owned trigger is only writable from debug mode.
  assign w_wr_ok      = ~r_dmode | i_dbg_mode;
  assign w_wr1        = i_wr_tdata1 & w_wr_ok;
  assign w_unused_cfg = CHAIN_CAP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dmode   <= 1'b0;
      r_hit     <= 1'b0;
      r_select  <= 1'b0;
      r_action  <= 1'b0;
      r_match   <= 1'b0;
      r_m       <= 1'b0;
      r_execute <= 1'b0;
      r_store   <= 1'b0;
      r_load    <= 1'b0;
      r_tdata2  <= '0;
    end else begin
      if (w_wr1) begin
        if (i_dbg_mode) r_dmode <= i_wr_data[TD1_DMODE];
        r_select  <= i_wr_data[TD1_SELECT];
        r_action  <= i_wr_data[TD1_ACTION];
        r_match   <= i_wr_data[TD1_MATCH];
        r_m       <= i_wr_data[TD1_M];
        r_execute <= i_wr_data[TD1_EXECUTE];
        r_store   <= i_wr_data[TD1_STORE];
        r_load    <= i_wr_data[TD1_LOAD];
      end
      if (i_hit_set)  r_hit <= 1'b1;
      else if (w_wr1) r_hit <= i_wr_data[TD1_HIT];
      if (i_wr_tdata2 && w_wr_ok) r_tdata2 <= i_wr_data;
    end
  end

`ifdef EH2_TRIGGER_CHAIN_EN
  if (CHAIN_CAP) begin : g_chain
    logic r_chain;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_chain <= 1'b0;
      else if (w_wr1) r_chain <= i_wr_data[TD1_CHAIN];
    end
    assign w_chain = r_chain;
  end else begin : g_no_chain
    assign w_chain = 1'b0;
  end
`else
  assign w_chain = 1'b0;
`endif

  assign o_chain = w_chain;

  always_comb begin
    o_tdata1                 = '0;
    o_tdata1[31:28]          = MCONTROL_TYPE;
    o_tdata1[26:21]          = MCONTROL_MAXMASK;
    o_tdata1[TD1_DMODE]      = r_dmode;
    o_tdata1[TD1_HIT]        = r_hit;
    o_tdata1[TD1_SELECT]     = r_select;
    o_tdata1[TD1_ACTION]     = r_action;
    o_tdata1[TD1_CHAIN]      = w_chain;
    o_tdata1[TD1_MATCH]      = r_match;
    o_tdata1[TD1_M]          = r_m;
    o_tdata1[TD1_EXECUTE]    = r_execute;
    o_tdata1[TD1_STORE]      = r_store;
    o_tdata1[TD1_LOAD]       = r_load;
  end

  assign o_pkt.select  = r_select;
  assign o_pkt.match   = r_match;
  assign o_pkt.store   = r_store;
  assign o_pkt.load    = r_load;
  assign o_pkt.execute = r_execute;
  assign o_pkt.m       = r_m;
  assign o_pkt.tdata2  = r_tdata2;

endmodule

// File: rtl/eh2_dec_trigger_csr.sv
// Per-thread debug-trigger CSR file (tselect/tdata1/tdata2, 4 triggers per thread).
// Optional trigger chaining on pairs (0,1)/(2,3) under EH2_TRIGGER_CHAIN_EN.
module eh2_dec_trigger_csr
  import eh2_pkg::*;
#(
  parameter int unsigned NUM_THREADS = 2,
  parameter int unsigned NUM_TRIG    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          csr_wr_en,
  input  logic                          csr_wr_tid,
  input  logic [11:0]                   csr_wr_addr,
  input  logic [31:0]                   csr_wr_data,
  input  logic                          csr_rd_en,
  input  logic                          csr_rd_tid,
  input  logic [11:0]                   csr_rd_addr,
  output logic [31:0]                   csr_rd_data,
  output logic                          csr_rd_valid,
  input  logic [NUM_THREADS-1:0]        dbg_mode,
  input  logic [NUM_THREADS*NUM_TRIG-1:0] trigger_hit,
  output eh2_trigger_pkt_t [NUM_THREADS-1:0][NUM_TRIG-1:0] trigger_pkt_any
);

  logic [1:0]  w_tsel   [NUM_THREADS];
  logic [31:0] w_tdata1 [NUM_THREADS][NUM_TRIG];
  logic [31:0] w_rd_val;
  logic [31:0] r_rd_data;
  logic        r_rd_valid;

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
    logic [1:0]          r_tsel;
    logic                w_wr_thr;
    logic [NUM_TRIG-1:0] w_chain;
    logic [NUM_TRIG-1:0] w_hit_set;

    assign w_wr_thr  = csr_wr_en && (csr_wr_tid == 1'(t));
    assign w_tsel[t] = r_tsel;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        r_tsel <= '0;
      else if (w_wr_thr && csr_wr_addr == TSELECT && csr_wr_data[31:2] == '0)
        r_tsel <= csr_wr_data[1:0];
    end

`ifdef EH2_TRIGGER_CHAIN_EN
    // A chained pair records hits only when both triggers fire together.
    for (genvar k = 0; k < NUM_TRIG / 2; k++) begin : g_pair
      logic w_lo, w_hi;
      assign w_lo = trigger_hit[t*NUM_TRIG + 2*k];
      assign w_hi = trigger_hit[t*NUM_TRIG + 2*k + 1];
      assign w_hit_set[2*k]   = w_chain[2*k] ? (w_lo & w_hi) : w_lo;
      assign w_hit_set[2*k+1] = w_chain[2*k] ? (w_lo & w_hi) : w_hi;
    end
`else
    logic w_unused_chain;
    assign w_unused_chain = ^w_chain;
    assign w_hit_set      = trigger_hit[t*NUM_TRIG +: NUM_TRIG];
`endif

    for (genvar i = 0; i < NUM_TRIG; i++) begin : g_trig
      eh2_dec_trigger_reg #(
        .CHAIN_CAP ((i % 2) == 0)
      ) u_reg (
        .clk         (clk),
        .rst         (rst),
        .i_wr_tdata1 (w_wr_thr && csr_wr_addr == TDATA1 && r_tsel == 2'(i)),
        .i_wr_tdata2 (w_wr_thr && csr_wr_addr == TDATA2 && r_tsel == 2'(i)),
        .i_wr_data   (csr_wr_data),
        .i_dbg_mode  (dbg_mode[t]),
        .i_hit_set   (w_hit_set[i]),
        .o_tdata1    (w_tdata1[t][i]),
        .o_chain     (w_chain[i]),
        .o_pkt       (trigger_pkt_any[t][i])
      );
    end
  end

  always_comb begin
    w_rd_val = '0;
    case (csr_rd_addr)
      TSELECT: w_rd_val = {30'b0, w_tsel[csr_rd_tid]};
      TDATA1:  w_rd_val = w_tdata1[csr_rd_tid][w_tsel[csr_rd_tid]];
      TDATA2:  w_rd_val = trigger_pkt_any[csr_rd_tid][w_tsel[csr_rd_tid]].tdata2;
      default: w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= csr_rd_en;
      if (csr_rd_en) r_rd_data <= w_rd_val;
    end
  end

  assign csr_rd_data  = r_rd_data;
  assign csr_rd_valid = r_rd_valid;

endmodule
